// File: rtl/fir_seq_if.sv
// Sample, coefficient-SRAM and MAC-control signals of the sequential FIR controller.
// slave is the controller side; master is the host/datapath side.
interface fir_seq_if #(
  parameter int NUM_TAP  = 10,
  parameter int SAMPLE_W = 3
);
  logic                          iEnSample;
  logic [SAMPLE_W-1:0]           iFirIn;
  logic                          iCoeffUpdate;
  logic                          iCsnRam;
  logic                          iWrnRam;
  logic [3:0]                    iAddrRam;
  logic [15:0]                   iWrDtRam;
  logic                          oCsn;
  logic                          oWrn;
  logic [3:0]                    oAddr;
  logic [15:0]                   oWrDt;
  logic [NUM_TAP*SAMPLE_W-1:0]   oDelay;
  logic                          oEnMul;
  logic                          oEnAddAcc;
  logic                          oMacValid;
  logic                          oBusy;

  modport slave (
    input  iEnSample, iFirIn, iCoeffUpdate, iCsnRam, iWrnRam, iAddrRam, iWrDtRam,
    output oCsn, oWrn, oAddr, oWrDt, oDelay, oEnMul, oEnAddAcc, oMacValid, oBusy
  );

  modport master (
    output iEnSample, iFirIn, iCoeffUpdate, iCsnRam, iWrnRam, iAddrRam, iWrDtRam,
    input  oCsn, oWrn, oAddr, oWrDt, oDelay, oEnMul, oEnAddAcc, oMacValid, oBusy
  );
endinterface

// File: rtl/fir_seq.sv
// Sequential FIR controller: sample delay chain, coefficient SRAM sequencing
// and MAC enables, with a host pass-through window for coefficient updates.
module fir_seq #(
  parameter int NUM_TAP  = 10,
  parameter int SAMPLE_W = 3
) (
  input  logic     iClk12M,
  input  logic     iRst,
  fir_seq_if.slave bus
);

  localparam int         DLY_W    = NUM_TAP * SAMPLE_W;
  localparam logic [3:0] LAST_TAP = 4'(NUM_TAP - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    RUN   = 3'd2,
    FLUSH = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [DLY_W-1:0] delay_q, delay_d;
  logic             en_mul_q;
  logic             mac_valid_q;
  logic             busy_q;

  logic             csn_s;
  logic             wrn_s;
  logic [3:0]       addr_s;
  logic [15:0]      wrdt_s;

  // State register, tap counter and delay chain
  always_ff @(posedge iClk12M or posedge iRst) begin
    if (iRst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      delay_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      delay_q <= delay_d;
    end
  end

  // Next-state, counter and sample-acceptance logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    delay_d = delay_q;
    case (state_q)
      IDLE: begin
        if (bus.iCoeffUpdate) begin
          state_d = LOAD;
        end else if (bus.iEnSample) begin
          state_d = RUN;
          cnt_d   = 4'd0;
          delay_d = {delay_q[DLY_W-SAMPLE_W-1:0], bus.iFirIn};
        end else begin
          state_d = IDLE;
        end
      end
      LOAD: begin
        if (bus.iCoeffUpdate) begin
          state_d = LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (cnt_q == LAST_TAP) begin
          state_d = FLUSH;
          cnt_d   = 4'd0;
        end else begin
          cnt_d   = cnt_q + 4'd1;
        end
      end
      FLUSH: begin
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // SRAM port: host pass-through while loading, tap-address read while running
  always_comb begin
    csn_s  = 1'b1;
    wrn_s  = 1'b1;
    addr_s = 4'd0;
    wrdt_s = 16'd0;
    case (state_q)
      LOAD: begin
        csn_s  = bus.iCsnRam;
        wrn_s  = bus.iWrnRam;
        addr_s = bus.iAddrRam;
        wrdt_s = bus.iWrDtRam;
      end
      RUN: begin
        csn_s  = 1'b0;
        addr_s = cnt_q;
      end
      default: begin
        csn_s  = 1'b1;
      end
    endcase
  end

  // MAC enables lag RUN by one cycle to match the synchronous SRAM read latency
  always_ff @(posedge iClk12M or posedge iRst) begin
    if (iRst) begin
      en_mul_q    <= 1'b0;
      mac_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      en_mul_q    <= (state_q == RUN);
      mac_valid_q <= (state_d == DONE);
      busy_q      <= (state_d != IDLE);
    end
  end

  assign bus.oCsn      = csn_s;
  assign bus.oWrn      = wrn_s;
  assign bus.oAddr     = addr_s;
  assign bus.oWrDt     = wrdt_s;
  assign bus.oDelay    = delay_q;
  assign bus.oEnMul    = en_mul_q;
  assign bus.oEnAddAcc = en_mul_q;
  assign bus.oMacValid = mac_valid_q;
  assign bus.oBusy     = busy_q;

endmodule

// File: tb/tb_fir_seq.sv
// Scoreboard bench for fir_seq: expected delay-chain contents are queued at each
// accepted strobe and compared when oMacValid closes the frame.
module tb_fir_seq;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fir_seq_if bus_if ();

  fir_seq dut (
    .iClk12M (clk),
    .iRst    (rst),
    .bus     (bus_if)
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [29:0] exp_dly;
  logic [29:0] sb_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus_if.iEnSample    = 1'b0;
    bus_if.iFirIn       = 3'd0;
    bus_if.iCoeffUpdate = 1'b0;
    bus_if.iCsnRam      = 1'b1;
    bus_if.iWrnRam      = 1'b1;
    bus_if.iAddrRam     = 4'd0;
    bus_if.iWrDtRam     = 16'd0;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_csn"},   32'(bus_if.oCsn),      32'd1);
    chk({tag, "_wrn"},   32'(bus_if.oWrn),      32'd1);
    chk({tag, "_addr"},  32'(bus_if.oAddr),     32'd0);
    chk({tag, "_wrdt"},  32'(bus_if.oWrDt),     32'd0);
    chk({tag, "_enmul"}, 32'(bus_if.oEnMul),    32'd0);
    chk({tag, "_enacc"}, 32'(bus_if.oEnAddAcc), 32'd0);
    chk({tag, "_mv"},    32'(bus_if.oMacValid), 32'd0);
    chk({tag, "_busy"},  32'(bus_if.oBusy),     32'd0);
  endtask

  // Strobe sample s in the current (IDLE) cycle, then follow cycles c0..c12.
  task automatic run_frame(input logic [2:0] s, input int drop_at, input int coef_at,
                           input int rst_at);
    int pulses;
    pulses = 0;
    bus_if.iEnSample = 1'b1;
    bus_if.iFirIn    = s;
    exp_dly = {exp_dly[26:0], s};
    sb_q.push_back(exp_dly);
    for (int c = 0; c <= 12; c++) begin
      step();
      bus_if.iEnSample = (c == drop_at);
      bus_if.iFirIn    = ~s;
      if (c == coef_at) begin
        bus_if.iCoeffUpdate = 1'b1;
        bus_if.iCsnRam      = 1'b0;
        bus_if.iAddrRam     = 4'd7;
      end
      if (c == rst_at) begin
        rst = 1'b1;
        #1;
        chk_quiet("rst_mid");
        chk("rst_mid_dly", 32'(bus_if.oDelay), 32'd0);
        void'(sb_q.pop_back());
        exp_dly = '0;
        step();
        rst = 1'b0;
        for (int k = 0; k < 14; k++) begin
          step();
          chk("post_rst_mv", 32'(bus_if.oMacValid), 32'd0);
        end
        chk("post_rst_busy", 32'(bus_if.oBusy), 32'd0);
        chk("post_rst_dly", 32'(bus_if.oDelay), 32'd0);
        return;
      end
      #1;
      if (bus_if.oEnMul) pulses++;
      chk("addr",  32'(bus_if.oAddr),     32'((c <= 9) ? c : 0));
      chk("csn",   32'(bus_if.oCsn),      32'((c <= 9) ? 0 : 1));
      chk("wrn",   32'(bus_if.oWrn),      32'd1);
      chk("enmul", 32'(bus_if.oEnMul),    32'((c >= 1 && c <= 10) ? 1 : 0));
      chk("enacc", 32'(bus_if.oEnAddAcc), 32'((c >= 1 && c <= 10) ? 1 : 0));
      chk("busy",  32'(bus_if.oBusy),     32'((c <= 11) ? 1 : 0));
      chk("dly",   32'(bus_if.oDelay),    32'(exp_dly));
      chk("mv",    32'(bus_if.oMacValid), 32'((c == 11) ? 1 : 0));
      if (bus_if.oMacValid) begin
        if (sb_q.size() == 0) chk("sb_empty", 32'd1, 32'd0);
        else                  chk("sb_dly", 32'(bus_if.oDelay), 32'(sb_q.pop_front()));
      end
    end
    chk("pulses", 32'(pulses), 32'd10);
    if (coef_at >= 0) begin
      step();
      chk("late_load_busy", 32'(bus_if.oBusy), 32'd1);
      chk("late_load_csn",  32'(bus_if.oCsn),  32'd0);
      chk("late_load_addr", 32'(bus_if.oAddr), 32'd7);
      idle_inputs();
      step();
      chk("load_exit_busy", 32'(bus_if.oBusy), 32'd0);
      chk("load_exit_csn",  32'(bus_if.oCsn),  32'd1);
    end
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    exp_dly = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_quiet("reset");
    chk("reset_dly", 32'(bus_if.oDelay), 32'd0);
    rst = 1'b0;
    step();
    chk_quiet("idle");

    run_frame(3'b101, -1, -1, -1);
    chk("dly_101", 32'(bus_if.oDelay), 32'h0000_0005);
    run_frame(3'b011, -1, -1, -1);
    chk("dly_011", 32'(bus_if.oDelay), 32'h0000_002B);

    for (int i = 0; i < 11; i++) run_frame(3'b111, -1, -1, -1);
    chk("dly_all1", 32'(bus_if.oDelay), 32'h3FFF_FFFF);
    run_frame(3'b000, -1, -1, -1);
    chk("dly_shift0", 32'(bus_if.oDelay), 32'h3FFF_FFF8);

    // dropped strobe in c4 and coefficient request in c3 of the same frame
    run_frame(3'b010, 4, 3, -1);

    // host pass-through while loading; strobes are ignored
    bus_if.iCoeffUpdate = 1'b1;
    step();
    bus_if.iCsnRam  = 1'b0;
    bus_if.iWrnRam  = 1'b0;
    bus_if.iAddrRam = 4'd3;
    bus_if.iWrDtRam = 16'h0005;
    #1;
    chk("load_csn",  32'(bus_if.oCsn),  32'd0);
    chk("load_wrn",  32'(bus_if.oWrn),  32'd0);
    chk("load_addr", 32'(bus_if.oAddr), 32'd3);
    chk("load_wrdt", 32'(bus_if.oWrDt), 32'h0000_0005);
    chk("load_busy", 32'(bus_if.oBusy), 32'd1);
    bus_if.iEnSample = 1'b1;
    bus_if.iFirIn    = 3'b110;
    step();
    bus_if.iEnSample = 1'b0;
    bus_if.iAddrRam  = 4'd9;
    bus_if.iWrDtRam  = 16'hA5A5;
    #1;
    chk("load_dly",   32'(bus_if.oDelay), 32'(exp_dly));
    chk("load_addr2", 32'(bus_if.oAddr),  32'd9);
    chk("load_wrdt2", 32'(bus_if.oWrDt),  32'h0000_A5A5);
    chk("load_enmul", 32'(bus_if.oEnMul), 32'd0);
    bus_if.iCoeffUpdate = 1'b0;
    step();
    chk("unload_busy", 32'(bus_if.oBusy), 32'd0);
    chk("unload_csn",  32'(bus_if.oCsn),  32'd1);
    chk("unload_wrdt", 32'(bus_if.oWrDt), 32'd0);
    idle_inputs();

    // reset in c5 aborts the frame
    run_frame(3'b110, -1, -1, 5);

    run_frame(3'b010, -1, -1, -1);
    chk("recover_dly", 32'(bus_if.oDelay), 32'h0000_0002);
    chk("sb_left", 32'(sb_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fir_seq.md
FIR_SEQ -- requirements
Module: fir_seq

Interface
REQ-001 Parameter NUM_TAP, default 10, number of taps / coefficients per output; only 10 is supported.
REQ-002 Parameter SAMPLE_W, default 3, sample width in bits; only 3 is supported.
REQ-003 iClk12M  in  1  single system clock, 12 MHz; all flops use its rising edge.
REQ-004 iRst  in  1  reset, asynchronous, active-high.
REQ-005 iEnSample  in  1  one-cycle strobe; a new input sample is present on iFirIn.
REQ-006 iFirIn  in  3  input sample.
REQ-007 iCoeffUpdate  in  1  level; host owns the coefficient SRAM while this is 1.
REQ-008 iCsnRam, iWrnRam  in  1 each  host SRAM chip-select / write-enable, active-low.
REQ-009 iAddrRam  in  4  host SRAM address.
REQ-010 iWrDtRam  in  16  host SRAM write data.
REQ-011 oCsn, oWrn  out  1 each  coefficient SRAM chip-select / write-enable, active-low.
REQ-012 oAddr  out  4  coefficient SRAM address.
REQ-013 oWrDt  out  16  coefficient SRAM write data.
REQ-014 oDelay  out  30  delay chain, 10 x 3-bit taps; tap k occupies [3k+2:3k]; tap 0 is the newest sample.
REQ-015 oEnMul, oEnAddAcc  out  1 each  MAC step enables, 10 pulses per output.
REQ-016 oMacValid  out  1  one-cycle strobe; the MAC output is valid in this cycle.
REQ-017 oBusy  out  1  high whenever the state is not IDLE.

Function
REQ-018 The FSM shall have exactly these states: IDLE, LOAD, RUN, FLUSH, DONE.
REQ-019 IDLE transitions:
- iCoeffUpdate=1 -> LOAD; this has priority over iEnSample.
- Otherwise iEnSample=1 -> RUN, with the tap counter set to 0.
REQ-020 LOAD behaviour:
- oCsn, oWrn, oAddr and oWrDt shall combinationally follow iCsnRam, iWrnRam, iAddrRam and iWrDtRam.
- The state shall return to IDLE on the first cycle in which iCoeffUpdate=0.
- iEnSample shall be ignored.
REQ-021 On the edge where IDLE accepts a sample, oDelay shall load {oDelay[26:0], iFirIn}; the oldest tap [29:27] is discarded.
REQ-022 oDelay shall change only on an accepted sample and shall stay stable throughout RUN, FLUSH and DONE.
REQ-023 RUN shall last 10 cycles (c0..c9). In cycle ck: oCsn=0, oWrn=1, oAddr=k.
- Counter value 9 -> FLUSH.
- The counter shall not exceed 9.
REQ-024 oEnMul shall be a registered copy of (state==RUN), asserted in cycles c1..c10, exactly 10 consecutive cycles. This aligns with the 1-cycle synchronous SRAM read latency, so coefficient k is on the SRAM output while pulse k+1 is active.
REQ-025 oEnAddAcc shall equal oEnMul in every cycle.
REQ-026 FLUSH (c10) shall last one cycle and then go to DONE.
REQ-027 DONE (c11) shall assert oMacValid for exactly one cycle and then go to IDLE.
REQ-028 Outside LOAD and RUN: oCsn=1, oWrn=1, oAddr=0, oWrDt=0.
REQ-029 iEnSample in RUN, FLUSH or DONE shall be dropped with no effect on state, oDelay or the counter.
REQ-030 iCoeffUpdate in RUN, FLUSH or DONE shall be ignored until IDLE.
REQ-031 A frame shall never produce a partial oEnMul burst; only reset can truncate one.
REQ-032 Minimum spacing between accepted samples shall be 12 cycles: a strobe is accepted in c12 at the earliest.

Reset
REQ-033 While iRst=1, asynchronously:
- state=IDLE, counter=0, oDelay=0.
- oEnMul=0, oEnAddAcc=0, oMacValid=0, oBusy=0.
- oCsn=1, oWrn=1, oAddr=0, oWrDt=0.
REQ-034 Reset asserted mid-frame shall abort the frame immediately. After release the block shall be in IDLE with an empty delay chain, and no oMacValid shall be issued for the aborted frame.

Verification
REQ-035 Reset, then strobe 3'b101 -> oDelay=0x00000005. A second strobe 3'b011 (>=12 cycles later) -> oDelay=0x0000002B.
REQ-036 Strobe at edge E0 -> oAddr 0..9 in c0..c9 with oCsn=0; oEnMul=oEnAddAcc=1 in c1..c10 only; oMacValid=1 in c11 only; oBusy=0 from c12.
REQ-037 Eleven accepted strobes of 3'b111 -> oDelay=0x3FFFFFFF; a further strobe of 3'b000 -> oDelay=0x3FFFFFF8.
REQ-038 iCoeffUpdate=1 with iCsnRam=0, iWrnRam=0, iAddrRam=3, iWrDtRam=0x0005 -> same cycle oCsn=0, oWrn=0, oAddr=3, oWrDt=0x0005. A strobe during LOAD leaves oDelay unchanged.
REQ-039 Strobe in c4 of a frame -> dropped: oDelay unchanged and still exactly 10 oEnMul pulses. iCoeffUpdate=1 in c3 -> LOAD entered only in c12.
REQ-040 iRst pulsed in c5 -> oEnMul=0, oCsn=1, oDelay=0 immediately, and no oMacValid follows.
